dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory slave: accepts byte/half/word loads and stores, flags
// out-of-window and misaligned accesses, and responds after a fixed wait-state delay.
module dmem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [1:0]  n_bytes,
    input  logic        l_unsigned,
    input  logic [31:0] wr_data,
    output logic        ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        addr_err
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;
    localparam logic [1:0]  WAIT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_wait_cnt;

    logic               w_accept;
    logic               w_in_range;
    logic               w_misalign;
    logic               w_fault;
    logic               w_we;
    logic               w_re;
    logic [IDX_W-1:0]   w_index;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rd_word;

    logic               r_is_load;
    logic               r_err;
    logic [1:0]         r_size;
    logic [1:0]         r_lane;
    logic               r_unsigned;

    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ext;
    logic               w_resp;

    assign w_accept   = req && ready && !rst;
    assign w_in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
    assign w_misalign = ((n_bytes == 2'd1) && addr[0]) ||
                        ((n_bytes == 2'd2) && (addr[1:0] != 2'b00));
    assign w_fault    = !w_in_range || (n_bytes == 2'd3) || w_misalign;
    assign w_we       = w_accept && write && !w_fault;
    assign w_re       = w_accept && !write && !w_fault;
    assign w_index    = IDX_W'((addr - BASE_ADDR) >> 2);

    // Narrow stores replicate their data across the word so each lane picks its own slice.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wr_data;
        case (n_bytes)
            2'd0: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wr_data[7:0]}};
            end
            2'd1: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wr_data[15:0]}};
            end
            2'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [MEM_WORDS];
            logic [7:0] r_rd_byte;

            always_ff @(posedge clk) begin
                if (w_we && w_be[gi]) begin
                    r_mem[w_index] <= w_wdata[8*gi +: 8];
                end
                if (w_re) begin
                    r_rd_byte <= r_mem[w_index];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_rd_byte;
        end
    endgenerate

    // Access attributes held until the response; WAIT never overwrites them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_load  <= !write;
            r_err      <= w_fault;
            r_size     <= n_bytes;
            r_lane     <= addr[1:0];
            r_unsigned <= l_unsigned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_wait_cnt <= WAIT_INIT;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 2'd0)) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    w_state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_state_next = S_RESP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = w_rd_word[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (r_size)
            2'd0:    w_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = w_rd_word;
        endcase
    end

    // Outputs are forced quiet while rst is high, whatever state the register still holds.
    always_comb begin
        ready    = rst || (r_state != S_WAIT);
        w_resp   = !rst && (r_state == S_RESP);
        rd_valid = w_resp && r_is_load && !r_err;
        addr_err = w_resp && r_err;
        rd_data  = rd_valid ? w_ext : 32'd0;
    end

endmodule
